// File: rtl/commutation_monitor.sv
// Gate-word guard between the commutation FSM and the gate drivers: decodes the
// connected phase, checks shoot-through/overlap/dead-time/open rules, latches faults.
module commutation_monitor #(
  parameter int unsigned TOFF_MIN = 9,
  parameter int unsigned TON_MIN  = 1,
  parameter int unsigned OPEN_MAX = 64,
  parameter int unsigned CW       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  gate_in,
  input  logic        fault_clr,
  output logic [5:0]  gate_out,
  output logic [1:0]  conn_phase,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [15:0] comm_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] TOFF_C    = CW'(TOFF_MIN);
  localparam logic [CW-1:0] TON_C     = CW'(TON_MIN);
  localparam logic [CW-1:0] OPEN_LAST = CW'(OPEN_MAX - 1);

  state_t        state_q, state_d;
  logic [5:0]    prev_q, gate_out_q, gate_out_d;
  logic [CW-1:0] off_cnt_q, off_cnt_d, on_cnt_q, on_cnt_d, open_cnt_q, open_cnt_d;
  logic [1:0]    conn_phase_q, conn_phase_d, last_phase_q, last_phase_d;
  logic          fault_q, fault_d;
  logic [2:0]    fault_code_q, fault_code_d, viol_code_s;
  logic [15:0]   comm_cnt_q, comm_cnt_d;
  logic          rise_s, fall_s, viol_s, clear_s;

  function automatic logic [2:0] pop3(input logic [2:0] v);
    pop3 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]};
  endfunction

  // A forward and a reverse switch on different phases; only the single F[k]&R[k] pair is safe.
  function automatic logic shoot_through(input logic [5:0] g);
    logic [2:0] f, r;
    f = {g[5], g[3], g[1]};
    r = {g[4], g[2], g[0]};
    shoot_through = (|f) & (|r) & ~((f == r) & $onehot(f));
  endfunction

  function automatic logic overlap(input logic [5:0] g);
    logic [2:0] nf, nr;
    nf = pop3({g[5], g[3], g[1]});
    nr = pop3({g[4], g[2], g[0]});
    overlap = (nf > 3'd2) | (nr > 3'd2) | ((nf + nr) > 3'd3);
  endfunction

  function automatic logic [1:0] decode_phase(input logic [5:0] g);
    case (g)
      6'b110000: decode_phase = 2'b01;
      6'b001100: decode_phase = 2'b10;
      6'b000011: decode_phase = 2'b11;
      default:   decode_phase = 2'b00;
    endcase
  endfunction

  assign rise_s  = |(gate_in & ~prev_q);
  assign fall_s  = |(prev_q & ~gate_in);
  assign clear_s = fault_clr & (gate_in == 6'b000000);
  assign viol_s  = (viol_code_s != 3'b000);

  // Violation classification, highest-priority cause first; checks use pre-update counters.
  always_comb begin
    viol_code_s = 3'b000;
    if (state_q == ST_FAULT) begin
      viol_code_s = 3'b000;
    end else if (shoot_through(gate_in)) begin
      viol_code_s = 3'b001;
    end else if (overlap(gate_in)) begin
      viol_code_s = 3'b010;
    end else if (rise_s && (off_cnt_q < TOFF_C)) begin
      viol_code_s = 3'b011;
    end else if (fall_s && (on_cnt_q < TON_C)) begin
      viol_code_s = 3'b100;
    end else if ((state_q == ST_RUN) && (gate_in == 6'b000000) && (open_cnt_q == OPEN_LAST)) begin
      viol_code_s = 3'b101;
    end else begin
      viol_code_s = 3'b000;
    end
  end

  // Saturating dead-time and open-interval counters.
  always_comb begin
    off_cnt_d  = fall_s ? {CW{1'b0}} : ((off_cnt_q == CNT_MAX) ? off_cnt_q : off_cnt_q + 1'b1);
    on_cnt_d   = rise_s ? {CW{1'b0}} : ((on_cnt_q == CNT_MAX) ? on_cnt_q : on_cnt_q + 1'b1);
    open_cnt_d = {CW{1'b0}};
    if ((state_q == ST_RUN) && (gate_in == 6'b000000)) begin
      open_cnt_d = (open_cnt_q == CNT_MAX) ? open_cnt_q : open_cnt_q + 1'b1;
    end else begin
      open_cnt_d = {CW{1'b0}};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (viol_s) begin
          state_d = ST_FAULT;
        end else if (gate_in != 6'b000000) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (viol_s) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (clear_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: state_d = ST_FAULT;
    endcase
  end

  // FSM output logic: the offending word is never forwarded.
  always_comb begin
    gate_out_d   = gate_in;
    conn_phase_d = 2'b00;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    comm_cnt_d   = comm_cnt_q;
    last_phase_d = last_phase_q;
    if ((state_q == ST_FAULT) || viol_s) begin
      gate_out_d = 6'b000000;
    end else begin
      gate_out_d = gate_in;
    end
    if (state_q == ST_FAULT) begin
      conn_phase_d = 2'b00;
    end else begin
      conn_phase_d = decode_phase(gate_out_d);
    end
    if (viol_s) begin
      fault_d      = 1'b1;
      fault_code_d = viol_code_s;
    end else if ((state_q == ST_FAULT) && clear_s) begin
      fault_d      = 1'b0;
      fault_code_d = 3'b000;
    end else begin
      fault_d      = fault_q;
      fault_code_d = fault_code_q;
    end
    if ((conn_phase_d != 2'b00) && (conn_phase_d != last_phase_q)) begin
      comm_cnt_d   = comm_cnt_q + 16'd1;
      last_phase_d = conn_phase_d;
    end else begin
      comm_cnt_d   = comm_cnt_q;
      last_phase_d = last_phase_q;
    end
  end

  // Datapath and output registers; timing counters start saturated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q       <= 6'b000000;
      off_cnt_q    <= CNT_MAX;
      on_cnt_q     <= CNT_MAX;
      open_cnt_q   <= {CW{1'b0}};
      gate_out_q   <= 6'b000000;
      conn_phase_q <= 2'b00;
      last_phase_q <= 2'b00;
      fault_q      <= 1'b0;
      fault_code_q <= 3'b000;
      comm_cnt_q   <= 16'd0;
    end else begin
      prev_q       <= gate_in;
      off_cnt_q    <= off_cnt_d;
      on_cnt_q     <= on_cnt_d;
      open_cnt_q   <= open_cnt_d;
      gate_out_q   <= gate_out_d;
      conn_phase_q <= conn_phase_d;
      last_phase_q <= last_phase_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      comm_cnt_q   <= comm_cnt_d;
    end
  end

  assign gate_out   = gate_out_q;
  assign conn_phase = conn_phase_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign comm_cnt   = comm_cnt_q;

endmodule

// File: tb/tb_commutation_monitor.sv
// Self-checking bench for commutation_monitor: directed scenarios plus randomized
// gate sequences checked against a timestamp-based reference model.
module tb_commutation_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  gate_in = 6'd0;
  logic        fault_clr = 1'b0;
  logic [5:0]  gate_out;
  logic [1:0]  conn_phase;
  logic        fault;
  logic [2:0]  fault_code;
  logic [15:0] comm_cnt;

  commutation_monitor dut (
    .clk(clk), .rst(rst), .gate_in(gate_in), .fault_clr(fault_clr),
    .gate_out(gate_out), .conn_phase(conn_phase), .fault(fault),
    .fault_code(fault_code), .comm_cnt(comm_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: states 0=IDLE 1=RUN 2=FAULT, edges tracked as cycle timestamps.
  int          m_st;
  logic [5:0]  m_prev, m_gout;
  longint      m_n, m_tf, m_tr;
  int          m_zrun;
  logic        m_fault;
  logic [2:0]  m_code;
  logic [1:0]  m_cph, m_last;
  logic [15:0] m_cnt;
  logic [5:0]  pats [20];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_prev = 6'd0; m_gout = 6'd0; m_zrun = 0;
    m_tf = m_n - 1000; m_tr = m_n - 1000;
    m_fault = 1'b0; m_code = 3'd0; m_cph = 2'd0; m_last = 2'd0; m_cnt = 16'd0;
  endtask

  task automatic model_step(input logic [5:0] g, input logic c);
    longint offc, onc;
    logic rise, fall, shoot;
    logic [2:0] f, r;
    int nf, nr, zn, code;
    rise = |(g & ~m_prev);
    fall = |(m_prev & ~g);
    offc = m_n - m_tf - 1; if (offc > 255) offc = 255;
    onc  = m_n - m_tr - 1; if (onc > 255) onc = 255;
    f = {g[5], g[3], g[1]};
    r = {g[4], g[2], g[0]};
    shoot = 1'b0;
    for (int x = 0; x < 3; x++)
      for (int y = 0; y < 3; y++)
        if (x != y && f[x] && r[y]) shoot = 1'b1;
    nf = $countones(f);
    nr = $countones(r);
    zn = (m_st == 1 && g == 6'd0) ? m_zrun + 1 : 0;
    code = 0;
    if (m_st != 2) begin
      if (shoot) code = 1;
      else if (nf > 2 || nr > 2 || nf + nr > 3) code = 2;
      else if (rise && offc < 9) code = 3;
      else if (fall && onc < 1) code = 4;
      else if (zn >= 64) code = 5;
    end
    if (m_st == 2) begin
      m_gout = 6'd0;
      if (c && g == 6'd0) begin
        m_st = 0; m_fault = 1'b0; m_code = 3'd0;
      end
    end else if (code != 0) begin
      m_gout = 6'd0; m_fault = 1'b1; m_code = 3'(code); m_st = 2;
    end else begin
      m_gout = g;
      if (g != 6'd0) m_st = 1;
    end
    if (m_gout == 6'b110000) m_cph = 2'd1;
    else if (m_gout == 6'b001100) m_cph = 2'd2;
    else if (m_gout == 6'b000011) m_cph = 2'd3;
    else m_cph = 2'd0;
    if (m_cph != 2'd0 && m_cph != m_last) begin
      m_cnt = m_cnt + 16'd1;
      m_last = m_cph;
    end
    if (fall) m_tf = m_n;
    if (rise) m_tr = m_n;
    m_zrun = zn;
    m_prev = g;
    m_n++;
  endtask

  task automatic cyc(input logic [5:0] g, input logic c);
    gate_in = g;
    fault_clr = c;
    model_step(g, c);
    @(posedge clk);
    #1;
    check("gate_out", 16'(gate_out), 16'(m_gout));
    check("conn_phase", 16'(conn_phase), 16'(m_cph));
    check("fault", 16'(fault), 16'(m_fault));
    check("fault_code", 16'(fault_code), 16'(m_code));
    check("comm_cnt", comm_cnt, m_cnt);
  endtask

  task automatic hold(input logic [5:0] g, input int k);
    repeat (k) cyc(g, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p, k;
    logic [5:0] g;
    pats = '{6'b000000, 6'b110000, 6'b001100, 6'b000011, 6'b100000, 6'b010000,
             6'b001000, 6'b000100, 6'b000010, 6'b000001, 6'b101000, 6'b100010,
             6'b001010, 6'b010100, 6'b010001, 6'b000101, 6'b110000, 6'b001100,
             6'b000011, 6'b000000};
    m_n = 0;
    model_reset();
    #12;
    check("rst_gate_out", 16'(gate_out), 16'd0);
    check("rst_conn_phase", 16'(conn_phase), 16'd0);
    check("rst_fault", 16'(fault), 16'd0);
    check("rst_fault_code", 16'(fault_code), 16'd0);
    check("rst_comm_cnt", comm_cnt, 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // First phase A connection and a legal A->B step with positive current.
    cyc(6'b110000, 1'b0);
    check("first_gate_out", 16'(gate_out), 16'h0030);
    check("first_phase", 16'(conn_phase), 16'd1);
    check("first_cnt", comm_cnt, 16'd1);
    hold(6'b110000, 2);
    hold(6'b100000, 10);
    hold(6'b101000, 2);
    hold(6'b001000, 10);
    hold(6'b001100, 3);
    check("ab_fault", 16'(fault), 16'd0);
    check("ab_phase", 16'(conn_phase), 16'd2);
    check("ab_cnt", comm_cnt, 16'd2);

    // Shoot-through from 100000.
    hold(6'b100000, 10);
    cyc(6'b100100, 1'b0);
    check("st_gate_out", 16'(gate_out), 16'd0);
    check("st_fault", 16'(fault), 16'd1);
    check("st_code", 16'(fault_code), 16'd1);

    // Clear is ignored while gate_in is nonzero.
    cyc(6'b001100, 1'b1);
    check("clr_ign_fault", 16'(fault), 16'd1);
    check("clr_ign_code", 16'(fault_code), 16'd1);
    cyc(6'b000000, 1'b1);
    check("clr_fault", 16'(fault), 16'd0);
    check("clr_code", 16'(fault_code), 16'd0);

    // Off-time too short, then just long enough.
    hold(6'b000000, 12);
    hold(6'b110000, 3);
    hold(6'b100000, 2);
    cyc(6'b101000, 1'b0);
    check("toff_code", 16'(fault_code), 16'd3);
    cyc(6'b000000, 1'b1);
    hold(6'b000000, 12);
    hold(6'b110000, 3);
    hold(6'b100000, 10);
    hold(6'b101000, 3);
    check("toff_ok_fault", 16'(fault), 16'd0);

    // Open interval: 63 cycles tolerated, 64th faults.
    hold(6'b000000, 63);
    hold(6'b110000, 3);
    check("open63_fault", 16'(fault), 16'd0);
    hold(6'b000000, 63);
    check("open63b_fault", 16'(fault), 16'd0);
    cyc(6'b000000, 1'b0);
    check("open64_fault", 16'(fault), 16'd1);
    check("open64_code", 16'(fault_code), 16'd5);

    // On-time too short: rise immediately followed by fall.
    cyc(6'b000000, 1'b1);
    hold(6'b000000, 12);
    cyc(6'b110000, 1'b0);
    cyc(6'b100000, 1'b0);
    check("ton_code", 16'(fault_code), 16'd4);
    cyc(6'b000000, 1'b1);

    // Randomized gate sequences against the model.
    for (int seg = 0; seg < 400; seg++) begin
      if (seg == 200) begin
        rst = 1'b0;
        #2;
        model_reset();
        check("midrst_gate_out", 16'(gate_out), 16'd0);
        check("midrst_fault", 16'(fault), 16'd0);
        check("midrst_cnt", comm_cnt, 16'd0);
        @(posedge clk); #1;
        rst = 1'b1;
      end
      if (m_st == 2 && $urandom_range(0, 1) == 0) begin
        cyc(6'b000000, 1'b1);
      end else begin
        p = $urandom_range(0, 19);
        g = ($urandom_range(0, 9) == 0) ? 6'($urandom) : pats[p];
        k = $urandom_range(1, 14);
        for (int i = 0; i < k; i++) cyc(g, ($urandom_range(0, 7) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
